// File: rtl/idli_pkg.sv
// Shared types and constants for the idli nibble-serial core.
// Holds the SQI controller state encoding and frame sizes.
package idli_pkg;

    typedef logic [3:0]  slice_t;
    typedef logic [15:0] data_t;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        END
    } sqi_state_t;

    localparam int unsigned SQI_CMD_NIBBLES  = 2;
    localparam int unsigned SQI_ADDR_NIBBLES = 6;
    localparam int unsigned SQI_DATA_NIBBLES = 4;

    // Opcode followed by the 24b byte address of a 16b word.
    function automatic logic [31:0] sqi_header(input logic [7:0] cmd, input data_t addr);
        return {cmd, 7'b0, addr, 1'b0};
    endfunction

endpackage

// File: rtl/idli_sqi_shift_m.sv
// 32b load-and-shift register: emits the opcode and address MSB nibble first.
module idli_sqi_shift_m
    import idli_pkg::*;
(
    input  logic        i_gck,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [31:0] i_data,
    input  logic        i_shift,
    output slice_t      o_nibble
);

    logic [31:0] sr_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_gck or posedge i_rst) begin
        if (i_rst) begin
            sr_q <= '0;
        end else if (i_load) begin
            sr_q <= i_data;
        end else if (i_shift) begin
            sr_q <= {sr_q[27:0], 4'h0};
        end
    end

    // Zeros shift in, so the output idles at 0 once the header is out.
    assign o_nibble = sr_q[31:28];

endmodule

// File: rtl/idli_sqi_m.sv
// SQI memory controller: 16b word load/store as command, address, dummy, 4 data nibbles.
// Optional build macro IDLI_SQI_BURST_EN: chain a sequential request from END back to DATA.
module idli_sqi_m
    import idli_pkg::*;
#(
    parameter logic [7:0]  CMD_READ     = 8'h03,
    parameter logic [7:0]  CMD_WRITE    = 8'h02,
    parameter int unsigned DUMMY_CYCLES = 2
) (
    input  logic   i_sqi_gck,
    input  logic   i_sqi_rst,
    input  logic   i_sqi_req,
    input  logic   i_sqi_wr,
    input  data_t  i_sqi_addr,
    output logic   o_sqi_ack,
    input  slice_t i_sqi_wr_data,
    output logic   o_sqi_wr_rdy,
    output slice_t o_sqi_rd_data,
    output logic   o_sqi_rd_vld,
    output logic   o_sqi_done,
    output logic   o_sqi_cs_n,
    output logic   o_sqi_sck_en,
    output slice_t o_sqi_sio,
    output logic   o_sqi_sio_oe,
    input  slice_t i_sqi_sio
);

    localparam logic [2:0] CMD_LAST   = 3'(SQI_CMD_NIBBLES - 1);
    localparam logic [2:0] ADDR_LAST  = 3'(SQI_ADDR_NIBBLES - 1);
    localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_CYCLES - 1);
    localparam logic [2:0] DATA_LAST  = 3'(SQI_DATA_NIBBLES - 1);

    sqi_state_t state_q;
    logic [2:0] cnt_q;
    logic       wr_q;
    data_t      addr_q;
    logic       cs_n_q, sck_en_q, sio_oe_q, wr_rdy_q, rd_vld_q, done_q;
    slice_t     rd_data_q;
    slice_t     hdr_nibble;
    logic       accept;
    logic       burst_hit;

    assign accept = (state_q == IDLE) && i_sqi_req;

`ifdef IDLI_SQI_BURST_EN
    // A wrap from 16'hFFFF to 0 is not contiguous in the memory, so it never chains.
    assign burst_hit = (state_q == END) && i_sqi_req && (i_sqi_wr == wr_q)
                    && (i_sqi_addr == addr_q + 16'd1) && (addr_q != 16'hFFFF);
`else
    assign burst_hit = 1'b0;
`endif

    idli_sqi_shift_m u_shift (
        .i_gck    (i_sqi_gck),
        .i_rst    (i_sqi_rst),
        .i_load   (accept),
        .i_data   (sqi_header(i_sqi_wr ? CMD_WRITE : CMD_READ, i_sqi_addr)),
        .i_shift  ((state_q == CMD) || (state_q == ADDR)),
        .o_nibble (hdr_nibble)
    );

    always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
        if (i_sqi_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            cs_n_q    <= 1'b1;
            sck_en_q  <= 1'b0;
            sio_oe_q  <= 1'b0;
            wr_rdy_q  <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            case (state_q)
                IDLE: if (i_sqi_req) begin
                    wr_q     <= i_sqi_wr;
                    addr_q   <= i_sqi_addr;
                    state_q  <= CMD;
                    cnt_q    <= '0;
                    cs_n_q   <= 1'b0;
                    sck_en_q <= 1'b1;
                    sio_oe_q <= 1'b1;
                end
                CMD: if (cnt_q == CMD_LAST) begin
                    state_q <= ADDR;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 3'd1;
                end
                ADDR: if (cnt_q == ADDR_LAST) begin
                    cnt_q <= '0;
                    if (wr_q) begin
                        state_q  <= DATA;
                        wr_rdy_q <= 1'b1;
                    end else begin
                        // Loads turn the bus around here, before the memory drives.
                        state_q  <= DUMMY;
                        sio_oe_q <= 1'b0;
                    end
                end else begin
                    cnt_q <= cnt_q + 3'd1;
                end
                DUMMY: if (cnt_q == DUMMY_LAST) begin
                    state_q <= DATA;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 3'd1;
                end
                DATA: begin
                    if (!wr_q) begin
                        rd_data_q <= i_sqi_sio;
                        rd_vld_q  <= 1'b1;
                    end
                    if (cnt_q == DATA_LAST) begin
                        state_q  <= END;
                        cnt_q    <= '0;
                        cs_n_q   <= 1'b1;
                        sck_en_q <= 1'b0;
                        sio_oe_q <= 1'b0;
                        wr_rdy_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                END: if (burst_hit) begin
                    addr_q   <= i_sqi_addr;
                    state_q  <= DATA;
                    cs_n_q   <= 1'b0;
                    sck_en_q <= 1'b1;
                    sio_oe_q <= wr_q;
                    wr_rdy_q <= wr_q;
                end else begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_sqi_ack     = accept || burst_hit;
    assign o_sqi_wr_rdy  = wr_rdy_q;
    assign o_sqi_rd_data = rd_data_q;
    assign o_sqi_rd_vld  = rd_vld_q;
    assign o_sqi_done    = done_q && !burst_hit;
    assign o_sqi_cs_n    = cs_n_q && !burst_hit;
    assign o_sqi_sck_en  = sck_en_q;
    assign o_sqi_sio_oe  = sio_oe_q;
    // Store slices pass straight from the register file read port to the pads.
    assign o_sqi_sio     = wr_rdy_q ? i_sqi_wr_data : hdr_nibble;

endmodule
